// File: rtl/riscv_pkg.sv
// rtl/riscv_pkg.sv - shared datapath widths, ALU op encodings and one-hot check
package riscv_pkg;

    localparam int XLEN = 32;
    localparam int RA_W = 5;

    localparam logic [3:0] ALU_AND = 4'b0001;
    localparam logic [3:0] ALU_OR  = 4'b0010;
    localparam logic [3:0] ALU_ADD = 4'b0100;
    localparam logic [3:0] ALU_SUB = 4'b1000;

    // True when exactly one bit of the ALU op is set
    function automatic logic alu_ctrl_is_one_hot(input logic [3:0] ctrl);
        return (ctrl != 4'b0000) && ((ctrl & (ctrl - 4'b0001)) == 4'b0000);
    endfunction

endpackage

// File: rtl/fwd_sel.sv
// rtl/fwd_sel.sv - combinational operand forward mux (EX/MEM over WB over register file)
module fwd_sel
    import riscv_pkg::*;
(
    input  logic [RA_W-1:0] rs_addr,
    input  logic [XLEN-1:0] rf_data,
    input  logic            exm_valid,
    input  logic [RA_W-1:0] exm_rd,
    input  logic [XLEN-1:0] exm_data,
    input  logic            wb_valid,
    input  logic [RA_W-1:0] wb_rd,
    input  logic [XLEN-1:0] wb_data,
    output logic [XLEN-1:0] data
);

    // The youngest producer wins; x0 is hardwired and never forwarded
    always_comb begin
        data = rf_data;
        if (rs_addr != '0) begin
            if (exm_valid && (exm_rd == rs_addr)) begin
                data = exm_data;
            end else if (wb_valid && (wb_rd == rs_addr)) begin
                data = wb_data;
            end
        end
    end

endmodule

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with forwarding, hold refresh and flush (option: ID_EX_FORWARD_EN)
module id_ex_stage
    import riscv_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [RA_W-1:0] in_rs1_addr,
    input  logic [RA_W-1:0] in_rs2_addr,
    input  logic [RA_W-1:0] in_rd_addr,
    input  logic [XLEN-1:0] in_rs1_data,
    input  logic [XLEN-1:0] in_rs2_data,
    input  logic [XLEN-1:0] in_imm,
    input  logic            in_alu_src,
    input  logic [3:0]      in_alu_ctrl,
    input  logic            fwd_exm_valid,
    input  logic [RA_W-1:0] fwd_exm_rd,
    input  logic [XLEN-1:0] fwd_exm_data,
    input  logic            fwd_wb_valid,
    input  logic [RA_W-1:0] fwd_wb_rd,
    input  logic [XLEN-1:0] fwd_wb_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] SrcA,
    output logic [XLEN-1:0] SrcB,
    output logic [3:0]      ALUControl,
    output logic [XLEN-1:0] out_rs2_data,
    output logic [RA_W-1:0] out_rd_addr,
    output logic            out_illegal
);

    logic            load;
    logic            ctrl_ok;
    logic [XLEN-1:0] cap_rs1;
    logic [XLEN-1:0] cap_rs2;

    assign in_ready = !out_valid || out_ready;
    assign load     = in_valid && in_ready;
    assign ctrl_ok  = alu_ctrl_is_one_hot(in_alu_ctrl);

`ifdef ID_EX_FORWARD_EN
    logic [RA_W-1:0] rs1_q;
    logic [RA_W-1:0] rs2_q;
    logic            alu_src_q;
    logic [XLEN-1:0] ref_rs1;
    logic [XLEN-1:0] ref_rs2;

    fwd_sel u_cap_rs1 (
        .rs_addr(in_rs1_addr), .rf_data(in_rs1_data),
        .exm_valid(fwd_exm_valid), .exm_rd(fwd_exm_rd), .exm_data(fwd_exm_data),
        .wb_valid(fwd_wb_valid), .wb_rd(fwd_wb_rd), .wb_data(fwd_wb_data),
        .data(cap_rs1)
    );

    fwd_sel u_cap_rs2 (
        .rs_addr(in_rs2_addr), .rf_data(in_rs2_data),
        .exm_valid(fwd_exm_valid), .exm_rd(fwd_exm_rd), .exm_data(fwd_exm_data),
        .wb_valid(fwd_wb_valid), .wb_rd(fwd_wb_rd), .wb_data(fwd_wb_data),
        .data(cap_rs2)
    );

    // Refresh muxes fall back to the currently held value when nothing matches
    fwd_sel u_ref_rs1 (
        .rs_addr(rs1_q), .rf_data(SrcA),
        .exm_valid(fwd_exm_valid), .exm_rd(fwd_exm_rd), .exm_data(fwd_exm_data),
        .wb_valid(fwd_wb_valid), .wb_rd(fwd_wb_rd), .wb_data(fwd_wb_data),
        .data(ref_rs1)
    );

    fwd_sel u_ref_rs2 (
        .rs_addr(rs2_q), .rf_data(out_rs2_data),
        .exm_valid(fwd_exm_valid), .exm_rd(fwd_exm_rd), .exm_data(fwd_exm_data),
        .wb_valid(fwd_wb_valid), .wb_rd(fwd_wb_rd), .wb_data(fwd_wb_data),
        .data(ref_rs2)
    );

    // Source addresses and operand-B select kept so a held entry can be refreshed
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rs1_q     <= '0;
            rs2_q     <= '0;
            alu_src_q <= 1'b0;
        end else if (!flush && load) begin
            rs1_q     <= in_rs1_addr;
            rs2_q     <= in_rs2_addr;
            alu_src_q <= in_alu_src;
        end
    end
`else
    logic unused_fwd;

    assign cap_rs1    = in_rs1_data;
    assign cap_rs2    = in_rs2_data;
    assign unused_fwd = ^{fwd_exm_valid, fwd_exm_rd, fwd_exm_data,
                          fwd_wb_valid, fwd_wb_rd, fwd_wb_data,
                          in_rs1_addr, in_rs2_addr};
`endif

    // Stage register: reset > flush > load > hold/refresh > drain
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_valid    <= 1'b0;
            out_illegal  <= 1'b0;
            SrcA         <= '0;
            SrcB         <= '0;
            out_rs2_data <= '0;
            out_rd_addr  <= '0;
            ALUControl   <= 4'b0000;
        end else if (flush) begin
            out_valid <= 1'b0;
        end else if (load) begin
            out_valid    <= 1'b1;
            SrcA         <= cap_rs1;
            SrcB         <= in_alu_src ? in_imm : cap_rs2;
            out_rs2_data <= cap_rs2;
            out_rd_addr  <= in_rd_addr;
            ALUControl   <= ctrl_ok ? in_alu_ctrl : 4'b0000;
            out_illegal  <= !ctrl_ok;
        end else if (out_valid && !out_ready) begin
`ifdef ID_EX_FORWARD_EN
            SrcA         <= ref_rs1;
            out_rs2_data <= ref_rs2;
            if (!alu_src_q) begin
                SrcB <= ref_rs2;
            end
`endif
        end else begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

Pipeline register between decode and execute that captures decoded operands and feeds the ALU's SrcA, SrcB and ALUControl inputs directly. It applies result forwarding from the EX/MEM and MEM/WB stages and holds its contents under downstream back-pressure. While holding, it keeps refreshing the stored operands from the forwarding paths. It supports a one-cycle flush for branch redirects.

## Interface

- XLEN, 32, datapath width
- RA_W, 5, register-address width
- clk  in  1  rising-edge clock
- rst_n  in  1  synchronous, active-low reset
- flush  in  1  discard the incoming and held instruction
- in_valid  in  1  decode presents an instruction
- in_ready  out  1  stage can accept
- in_rs1_addr, in_rs2_addr, in_rd_addr  in  RA_W  source/destination registers
- in_rs1_data, in_rs2_data  in  XLEN  register-file read data
- in_imm  in  XLEN  sign-extended immediate
- in_alu_src  in  1  0 = SrcB from rs2, 1 = SrcB from imm
- in_alu_ctrl  in  4  one-hot op: 0001 AND, 0010 OR, 0100 ADD, 1000 SUB
- fwd_exm_valid, fwd_wb_valid  in  1  forwarding source writes a register
- fwd_exm_rd, fwd_wb_rd  in  RA_W  forwarding destination
- fwd_exm_data, fwd_wb_data  in  XLEN  forwarding value
- out_valid  out  1  execute operands valid
- out_ready  in  1  execute consumes this cycle
- SrcA, SrcB  out  XLEN  ALU operands (registered)
- ALUControl  out  4  ALU op (registered)
- out_rs2_data  out  XLEN  forwarded rs2, used as store data
- out_rd_addr  out  RA_W  destination
- out_illegal  out  1  captured alu_ctrl was not one-hot

## Operation

- Forward select per operand: EX/MEM match beats WB match, and WB match beats register-file data. A match requires valid, rd == rs and rs != 0. x0 is never forwarded.
- Load: when in_valid && in_ready, capture the forwarded rs1 into SrcA, the forwarded rs2 into out_rs2_data, and SrcB = in_alu_src ? in_imm : forwarded rs2. Also capture rd, alu_ctrl and the rs1/rs2 addresses internally. Set out_valid.
- Illegal op: a non-one-hot in_alu_ctrl is stored as ALUControl = 0000 with out_illegal = 1. The ALU then yields 0.
- Hold: when out_valid && !out_ready, the outputs stay stable except for forwarding refresh.
  - Refresh: if a forward source matches a held rs address (same priority rules), update SrcA, out_rs2_data, and SrcB when alu_src = 0.
- Drain: out_valid && out_ready && !in_valid clears out_valid next cycle.
- in_ready = !out_valid || out_ready. This is a combinational path from out_ready.
- Flush: out_valid = 0 next cycle, the incoming instruction is dropped, and refresh is suppressed. Flush wins over load and hold.

## Timing

- Latency 1 cycle, in to out. Full throughput: one instruction per cycle when out_ready = 1.
- Reset (rst_n low at edge): out_valid, out_illegal = 0; SrcA, SrcB, out_rs2_data, out_rd_addr, ALUControl = 0; held addresses = 0. in_ready = 1 the cycle after reset.
- Reset mid-hold discards the held instruction.
- Reset has priority over flush, and flush has priority over load.
- Simultaneous load and drain: the new instruction replaces the old in the same edge, and out_valid stays 1.
- Both forward sources match: EX/MEM data is used.
- Refresh and load never coincide. A load implies the old entry was consumed.

## Configuration

- ID_EX_FORWARD_EN defined: forwarding and hold refresh are active as above.
- Not defined: fwd_* inputs are ignored and operands come straight from in_rs*_data and in_imm. The ports remain, and the internal rs address storage is removed. Hazard avoidance is then the control unit's job.

## Structure

- Shared package riscv_pkg: XLEN, RA_W, the ALU control localparams (ALU_AND, ALU_OR, ALU_ADD, ALU_SUB) and the one-hot check function. The ALU and the decoder use the same constants.
- One sub-module: fwd_sel, a combinational forward mux (rs_addr, rf_data, two fwd sources → data).
  - Instantiated twice for capture and twice for refresh.

## Test plan

- Reset: rst_n = 0 for 2 cycles with in_valid = 1 → out_valid = 0, SrcA = SrcB = 0, ALUControl = 0000, in_ready = 1.
- Basic ADD: rs1 = 5 → 10, rs2 = 6 → 3, alu_src = 0, ctrl = 0100 → next cycle SrcA = 10, SrcB = 3, ALUControl = 0100, out_valid = 1.
- Forward priority: rs1 = 7, fwd_exm(rd = 7, 0xAA) and fwd_wb(rd = 7, 0xBB) → SrcA = 0xAA. Same case with rs1 = 0 → SrcA = in_rs1_data.
- Hold refresh: out_ready = 0 for 3 cycles holding rs2 = 9, alu_src = 0; fwd_wb(rd = 9, 0x1234) in cycle 2 → SrcB = out_rs2_data = 0x1234 from cycle 3, and in_ready = 0 throughout.
- Flush during hold: held instruction, flush = 1 with in_valid = 1 → out_valid = 0 next cycle, and the incoming instruction does not appear.
- Illegal op: ctrl = 0110 → ALUControl = 0000, out_illegal = 1. Next legal op (0001) clears out_illegal.
